// File: rtl/ram_fill_engine.sv
// ram_fill_engine: drives a single-port RAM to either fill an inclusive address
// range with a constant, or delete one board row by shifting every row above it
// down by one and clearing row 0. One RAM access per cycle.
module ram_fill_engine #(
  parameter int                DATA_W  = 6,
  parameter int                ADDR_W  = 8,
  parameter int                DEPTH   = 240,
  parameter int                COLS    = 10,
  parameter int                RD_LAT  = 1,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic [ADDR_W-1:0] row,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              wren,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // One extra address bit so range checks and row*COLS never wrap.
  localparam int AW1  = ADDR_W + 1;
  localparam int ROWS = DEPTH / COLS;

  localparam logic [AW1-1:0] DEPTH_C    = AW1'(DEPTH);
  localparam logic [AW1-1:0] ROWS_C     = AW1'(ROWS);
  localparam logic [AW1-1:0] COLS_C     = AW1'(COLS);
  localparam logic [AW1-1:0] LAST_COL_C = AW1'(COLS - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FILL    = 3'd1;
  localparam logic [2:0] SH_RD   = 3'd2;
  localparam logic [2:0] SH_WAIT = 3'd3;
  localparam logic [2:0] SH_WR   = 3'd4;
  localparam logic [2:0] SH_TOP  = 3'd5;
  localparam logic [2:0] FIN     = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [AW1-1:0]    ptr_q, ptr_d;     // fill address, copy destination, or clear address
  logic [AW1-1:0]    end_q, end_d;     // last fill address
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              err_q, err_d;
  logic [1:0]        wcnt_q, wcnt_d;   // extra read-latency cycles spent in SH_WAIT
  logic [ADDR_W-1:0] rd_addr;          // copy source: the word one row above dst

  // Copy source is only used while ptr_q >= COLS, so the low bits never wrap.
  assign rd_addr = ptr_q[ADDR_W-1:0] - COLS_C[ADDR_W-1:0];

  // Next-state logic: command capture and validation, then sequencing of each mode.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    fill_d  = fill_q;
    err_d   = err_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d  = 1'b0;
          fill_d = fill_data;
          end_d  = {1'b0, end_addr};
          if (!mode) begin
            if ((end_addr < start_addr) || ({1'b0, end_addr} >= DEPTH_C)) begin
              err_d   = 1'b1;
              state_d = FIN;
            end else begin
              ptr_d   = {1'b0, start_addr};
              state_d = FILL;
            end
          end else if ({1'b0, row} >= ROWS_C) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else if (row == '0) begin
            ptr_d   = '0;
            state_d = SH_TOP;
          end else begin
            ptr_d   = ({1'b0, row} * COLS_C) + LAST_COL_C;
            state_d = SH_RD;
          end
        end
      end
      FILL: begin
        if (ptr_q == end_q) state_d = FIN;
        else                ptr_d   = ptr_q + 1'b1;
      end
      SH_RD: begin
        wcnt_d  = '0;
        state_d = (RD_LAT > 1) ? SH_WAIT : SH_WR;
      end
      SH_WAIT: begin
        if (wcnt_q == 2'(RD_LAT - 2)) state_d = SH_WR;
        else                          wcnt_d  = wcnt_q + 1'b1;
      end
      SH_WR: begin
        if (ptr_q == COLS_C) begin
          ptr_d   = '0;
          state_d = SH_TOP;
        end else begin
          ptr_d   = ptr_q - 1'b1;
          state_d = SH_RD;
        end
      end
      SH_TOP: begin
        if (ptr_q == LAST_COL_C) state_d = FIN;
        else                     ptr_d   = ptr_q + 1'b1;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from state only, so reset clears them without a clock edge.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    wren      = 1'b0;
    busy      = (state_q != IDLE);
    done      = (state_q == FIN);
    err       = (state_q == FIN) && err_q;
    case (state_q)
      FILL: begin
        ram_addr  = ptr_q[ADDR_W-1:0];
        ram_wdata = fill_q;
        wren      = 1'b1;
      end
      SH_RD, SH_WAIT: ram_addr = rd_addr;
      SH_WR: begin
        ram_addr  = ptr_q[ADDR_W-1:0];
        ram_wdata = ram_rdata;
        wren      = 1'b1;
      end
      SH_TOP: begin
        ram_addr  = ptr_q[ADDR_W-1:0];
        ram_wdata = CLR_VAL;
        wren      = 1'b1;
      end
      default: ;
    endcase
  end

  // State registers; asynchronous reset aborts any command in progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      end_q   <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_ram_fill_engine.sv
// Bench for ram_fill_engine: one instance with RD_LAT=1 driven from a vector
// table, one with RD_LAT=3 for the slow-read shift case, each with its own RAM.
module tb_ram_fill_engine;

  typedef struct {
    int mode;
    int sa;
    int ea;
    int fd;
    int rw;
    int ewr;    // expected write count
    int eerr;   // expected err on done
    int edone;  // expected cycle of done, counted from the start cycle
  } vec_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start1, start3;
  logic       mode;
  logic [7:0] start_addr, end_addr, row;
  logic [5:0] fill_data;

  logic [7:0] addr1, addr3;
  logic [5:0] wdata1, wdata3, rdata1, rdata3;
  logic       wren1, busy1, done1, err1;
  logic       wren3, busy3, done3, err3;

  logic [5:0] mem1 [0:255];
  logic [5:0] mem3 [0:255];
  logic [5:0] exp1 [0:255];
  logic [5:0] exp3 [0:255];
  logic [5:0] p0, p1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_fill_engine #(.RD_LAT(1)) dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .mode(mode),
    .start_addr(start_addr), .end_addr(end_addr), .fill_data(fill_data), .row(row),
    .ram_rdata(rdata1), .ram_addr(addr1), .ram_wdata(wdata1), .wren(wren1),
    .busy(busy1), .done(done1), .err(err1)
  );

  ram_fill_engine #(.RD_LAT(3)) dut3 (
    .clk(clk), .resetn(resetn), .start(start3), .mode(mode),
    .start_addr(start_addr), .end_addr(end_addr), .fill_data(fill_data), .row(row),
    .ram_rdata(rdata3), .ram_addr(addr3), .ram_wdata(wdata3), .wren(wren3),
    .busy(busy3), .done(done3), .err(err3)
  );

  // RAM models: one-cycle read for dut1, three-cycle read for dut3.
  always @(posedge clk) begin
    if (wren1) mem1[addr1] <= wdata1;
    rdata1 <= mem1[addr1];
    if (wren3) mem3[addr3] <= wdata3;
    p0     <= mem3[addr3];
    p1     <= p0;
    rdata3 <= p1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_ram1(input string name);
    int bad = 0;
    for (int a = 0; a < 256; a++) if (mem1[a] !== exp1[a]) bad++;
    chk(name, bad, 0);
  endtask

  // Reference model of one command on the dut1 RAM.
  task automatic model1(input vec_t v);
    if (v.eerr != 0) return;
    if (v.mode == 0) begin
      for (int a = v.sa; a <= v.ea; a++) exp1[a] = 6'(v.fd);
    end else begin
      for (int a = v.rw * 10 + 9; a >= 10; a--) exp1[a] = exp1[a - 10];
      for (int a = 0; a < 10; a++) exp1[a] = 6'd0;
    end
  endtask

  // Issue one command on dut1 (caller is just past a negedge), run it to done.
  task automatic run1(input vec_t v, input string tag);
    int cyc, wr, e, b1;
    bit got;
    mode       = v.mode[0];
    start_addr = v.sa[7:0];
    end_addr   = v.ea[7:0];
    fill_data  = v.fd[5:0];
    row        = v.rw[7:0];
    start1     = 1'b1;
    @(negedge clk);
    start1     = 1'b0;
    // Scramble command inputs: the engine must use what it captured.
    mode       = ~mode;
    start_addr = 8'hFF;
    end_addr   = 8'h00;
    fill_data  = ~fill_data;
    row        = 8'hFE;
    cyc = 1; wr = 0; e = -1; got = 0;
    b1  = int'(busy1);
    while (cyc <= 2000) begin
      if (wren1) wr++;
      if (done1) begin
        got = 1;
        e   = int'(err1);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_cycle"}, got ? cyc : -1, v.edone);
    chk({tag, "_writes"}, wr, v.ewr);
    chk({tag, "_err"}, e, v.eerr);
    chk({tag, "_busy_first"}, b1, 1);
    model1(v);
    @(negedge clk);
    chk({tag, "_busy_after"}, int'(busy1), 0);
    cmp_ram1({tag, "_ram"});
  endtask

  vec_t vec [0:10];

  initial begin
    int wr, dn, cyc, first_wr, bad_data, ignored_wr;
    vec_t rv;

    vec[0]  = '{1,   0,   0,  0,  2,  30, 0,  51};  // shift row 2, rows 0/1 hold 1..20
    vec[1]  = '{1,   0,   0,  0,  0,  10, 0,  11};  // row 0: clear only
    vec[2]  = '{0,  10,  19,  5,  0,  10, 0,  11};
    vec[3]  = '{0,   7,   7, 33,  0,   1, 0,   2};  // single word
    vec[4]  = '{1,   0,   0,  0, 23, 240, 0, 471};  // last valid row
    vec[5]  = '{0,   0, 240,  9,  0,   0, 1,   1};  // end past DEPTH
    vec[6]  = '{1,   0,   0,  0, 24,   0, 1,   1};  // row past ROWS
    vec[7]  = '{0,  20,  10,  9,  0,   0, 1,   1};  // end < start
    vec[8]  = '{0,   0, 239,  0,  0, 240, 0, 241};  // whole RAM
    vec[9]  = '{0, 239, 239, 63,  0,   1, 0,   2};  // top address
    vec[10] = '{0,   0, 255,  3,  0,   0, 1,   1};

    for (int a = 0; a < 256; a++) begin
      mem1[a] = 6'((a + 1) % 64);
      exp1[a] = 6'((a + 1) % 64);
      mem3[a] = 6'((a * 5 + 1) % 64);
      exp3[a] = 6'((a * 5 + 1) % 64);
    end

    resetn = 1'b0; start1 = 1'b0; start3 = 1'b0; mode = 1'b0;
    start_addr = '0; end_addr = '0; fill_data = '0; row = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs_dut1", int'({addr1, wdata1, wren1, busy1, done1, err1}), 0);
    chk("reset_outs_dut3", int'({addr3, wdata3, wren3, busy3, done3, err3}), 0);
    resetn = 1'b1;

    // Table: each command starts on the cycle after the previous done.
    for (int i = 0; i <= 10; i++) run1(vec[i], $sformatf("v%0d", i));

    // Reset in the middle of a fill: abort after the 4th write lands.
    rv = '{0, 10, 19, 44, 0, 10, 0, 11};
    mode = 1'b0; start_addr = 8'd10; end_addr = 8'd19; fill_data = 6'd44;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wr = 0; cyc = 0;
    while (wr < 4 && cyc < 50) begin
      if (wren1) wr++;
      if (wr < 4) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("rst_reached_4th_write", wr, 4);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("rst_async_outs", int'({addr1, wdata1, wren1, busy1, done1, err1}), 0);
    dn = 0; wr = 0;
    repeat (2) begin
      @(negedge clk);
      if (done1) dn++;
      if (wren1) wr++;
    end
    resetn = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done1) dn++;
      if (wren1) wr++;
    end
    chk("rst_no_done", dn, 0);
    chk("rst_no_more_writes", wr, 0);
    for (int a = 10; a <= 13; a++) exp1[a] = 6'd44;
    cmp_ram1("rst_partial_ram");
    run1(rv, "rst_rerun");

    // RD_LAT=3 shift of row 1 with a second start attempted while busy.
    mode = 1'b1; row = 8'd1;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cyc = 1; wr = 0; first_wr = -1; bad_data = 0; dn = 0;
    chk("lat3_first_rd_addr", int'(addr3), 9);
    while (cyc <= 500) begin
      if (cyc == 5) begin
        mode = 1'b0; start_addr = 8'd0; end_addr = 8'd239; fill_data = 6'd21;
        start3 = 1'b1;
      end else begin
        start3 = 1'b0;
      end
      if (wren3) begin
        wr++;
        if (first_wr < 0) first_wr = cyc;
        if (wr <= 10 && int'(wdata3) != int'(exp3[int'(addr3) - 10])) bad_data++;
      end
      if (done3) begin
        dn = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start3 = 1'b0;
    chk("lat3_done_cycle", dn ? cyc : -1, 51);
    chk("lat3_first_write_cycle", first_wr, 4);
    chk("lat3_writes", wr, 20);
    chk("lat3_copy_data", bad_data, 0);
    chk("lat3_err", int'(err3), 0);
    for (int a = 19; a >= 10; a--) exp3[a] = exp3[a - 10];
    for (int a = 0; a < 10; a++) exp3[a] = 6'd0;
    ignored_wr = 0; dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (wren3) ignored_wr++;
      if (busy3) dn++;
    end
    chk("lat3_ignored_start_writes", ignored_wr, 0);
    chk("lat3_ignored_start_busy", dn, 0);
    begin
      int bad = 0;
      for (int a = 0; a < 256; a++) if (mem3[a] !== exp3[a]) bad++;
      chk("lat3_ram", bad, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
